shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/mul_pkg.sv | 26 ++
 rtl/shadd_ctrl.sv | 130 +++++++++++++
 rtl/shift_add_multiplier.sv | 133 +++++++++++++
 tb/tb_shift_add_multiplier.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the shift-and-add multiplier:
//   state_t    : controller state encoding (IDLE, LOAD, RUN, DONE)
//   WIDTH_DEF  : default operand width (16)
//   CNT_W_DEF  : bit-counter width for the default operand width
//   cnt_width  : counter width needed to hold the value w
// ---------------------------------------------------------------------------
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

  // Width of a counter that must hold the value w (counts w down to 0).
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shadd_ctrl.sv
// ---------------------------------------------------------------------------
// shadd_ctrl
// Sequencer for the shift-and-add multiplier. Holds the FSM and the bit
// counter and tells the datapath when to capture, clear, add and shift.
//
// Optional feature: SHIFT_ADD_EARLY_TERM_EN adds the rest_zero input and the
// cnt output so the datapath can finish in one barrel-shift step.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active low
//   start     in   multiply request (honoured in IDLE and DONE only)
//   mplr_lsb  in   bit 0 of the multiplier shift register
//   rest_zero in   remaining multiplier bits above bit 0 are all zero (ET only)
//   capture   out  latch the operand inputs this edge
//   clear     out  clear the upper accumulator this edge (LOAD)
//   shift     out  perform one shift step this edge (RUN)
//   add       out  add the multiplicand before shifting
//   last      out  this shift step is the final one; latch the product
//   busy      out  registered, high in LOAD and RUN
//   done      out  registered, one-cycle pulse in DONE
//   cnt       out  remaining bit count (ET only)
// ---------------------------------------------------------------------------
import mul_pkg::*;

module shadd_ctrl #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mplr_lsb,
`ifdef SHIFT_ADD_EARLY_TERM_EN
  input  logic             rest_zero,
  output logic [CNT_W-1:0] cnt,
`endif
  output logic             capture,
  output logic             clear,
  output logic             shift,
  output logic             add,
  output logic             last,
  output logic             busy,
  output logic             done
);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             last_s;

  // Datapath strobes decoded from the current state.
  assign capture = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign clear   = (state_r == ST_LOAD);
  assign shift   = (state_r == ST_RUN);
  assign add     = shift && mplr_lsb;

`ifdef SHIFT_ADD_EARLY_TERM_EN
  // Finish either on the normal last bit or as soon as no set bits remain.
  assign last_s  = shift && ((cnt_r == CNT_W'(1)) || rest_zero);
  assign cnt     = cnt_r;
`else
  assign last_s  = shift && (cnt_r == CNT_W'(1));
`endif

  assign last = last_s;
  assign busy = busy_r;
  assign done = done_r;

  // FSM, bit counter and registered busy/done flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_LOAD: begin
          state_r <= ST_RUN;
          cnt_r   <= CNT_W'(WIDTH);
          busy_r  <= 1'b1;
          done_r  <= 1'b0;
        end
        ST_RUN: begin
          if (last_s) begin
            // Early termination may leave several bits, so force the count to 0.
            state_r <= ST_DONE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_RUN;
            cnt_r   <= cnt_r - CNT_W'(1);
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_LOAD;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
// Unsigned sequential multiplier, one multiplier bit per RUN cycle.
// The product is formed in {acc_hi, mplr_reg}: each step optionally adds the
// multiplicand into acc_hi and shifts the whole word (with carry) right.
//
// Optional feature: SHIFT_ADD_EARLY_TERM_EN -- finish as soon as the
// remaining multiplier bits are zero by shifting the rest in one cycle.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active low
//   start    in   multiply request (honoured in IDLE and DONE only)
//   mcand    in   multiplicand, captured when start is accepted
//   mplr     in   multiplier, captured when start is accepted
//   busy     out  high in LOAD and RUN
//   done     out  one-cycle pulse when the product is valid
//   product  out  2*WIDTH unsigned result, held until the next result
// ---------------------------------------------------------------------------
import mul_pkg::*;

module shift_add_multiplier #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplr,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   acc_hi_r;
  logic [WIDTH-1:0]   mplr_r;
  logic [2*WIDTH-1:0] product_r;

  logic               capture_s;
  logic               clear_s;
  logic               shift_s;
  logic               add_s;
  logic               last_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] shifted_s;

`ifdef SHIFT_ADD_EARLY_TERM_EN
  logic [CNT_W-1:0]   cnt_s;
  logic               rest_zero_s;
`endif

  shadd_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mplr_lsb  (mplr_r[0]),
`ifdef SHIFT_ADD_EARLY_TERM_EN
    .rest_zero (rest_zero_s),
    .cnt       (cnt_s),
`endif
    .capture   (capture_s),
    .clear     (clear_s),
    .shift     (shift_s),
    .add       (add_s),
    .last      (last_s),
    .busy      (busy),
    .done      (done)
  );

`ifdef SHIFT_ADD_EARLY_TERM_EN
  // Unprocessed multiplier bits live in mplr_r[cnt-1:0]; bit 0 is handled
  // by this cycle's add, so only bits 1..cnt-1 decide early termination.
  always_comb begin
    rest_zero_s = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      rest_zero_s = rest_zero_s & ~((i < int'(cnt_s)) & mplr_r[i]);
    end
  end
`endif

  // Adder and right shift. The (WIDTH+1)-bit sum keeps the carry, which is
  // shifted into the top of acc_hi so the product can never overflow.
  always_comb begin
    sum_s = {1'b0, acc_hi_r} + (add_s ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
`ifdef SHIFT_ADD_EARLY_TERM_EN
    if (rest_zero_s) begin
      // Remaining steps would only shift; do them all at once.
      shifted_s = {sum_s, mplr_r[WIDTH-1:1]} >> (cnt_s - CNT_W'(1));
    end else begin
      shifted_s = {sum_s, mplr_r[WIDTH-1:1]};
    end
`else
    shifted_s = {sum_s, mplr_r[WIDTH-1:1]};
`endif
  end

  // Operand, accumulator and product registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_r   <= {WIDTH{1'b0}};
      acc_hi_r  <= {WIDTH{1'b0}};
      mplr_r    <= {WIDTH{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
    end else if (capture_s) begin
      mcand_r <= mcand;
      mplr_r  <= mplr;
    end else if (clear_s) begin
      acc_hi_r <= {WIDTH{1'b0}};
    end else if (shift_s) begin
      acc_hi_r <= shifted_s[2*WIDTH-1:WIDTH];
      mplr_r   <= shifted_s[WIDTH-1:0];
      if (last_s) begin
        product_r <= shifted_s;
      end else begin
        product_r <= product_r;
      end
    end else begin
      mcand_r   <= mcand_r;
      acc_hi_r  <= acc_hi_r;
      mplr_r    <= mplr_r;
      product_r <= product_r;
    end
  end

  assign product = product_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
// Directed bench for shift_add_multiplier (WIDTH=16). Inputs change and
// outputs are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplr;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_vec;
  int n_err;
  int lat;
  int bcnt;
  logic b0;

  shift_add_multiplier #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mcand   (mcand),
    .mplr    (mplr),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Request a multiply, then wait (bounded) for done. lat_o counts edges
  // after the accepting edge until done is seen; busy_o counts busy samples
  // over the same window; busy0_o is busy right after the accepting edge.
  // With poke set, a start with operands 7*7 is issued mid-run.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit poke,
                        output int lat_o, output int busy_o, output logic busy0_o);
    mcand = a;
    mplr  = b;
    start = 1'b1;
    tick();
    start   = 1'b0;
    lat_o   = 0;
    busy_o  = 0;
    busy0_o = busy;
    while (!done && lat_o < 40) begin
      if (busy) busy_o++;
      if (poke && lat_o == 5) begin
        start = 1'b1;
        mcand = 16'h0007;
        mplr  = 16'h0007;
      end else begin
        start = 1'b0;
      end
      tick();
      lat_o++;
    end
    start = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    start = 1'b0;
    mcand = 16'h0000;
    mplr  = 16'h0000;
    repeat (3) tick();

    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_product", product, 32'h0);

    // Basic multiply, start on the very first edge after reset release.
    rst = 1'b1;
    run_op(16'd3, 16'd5, 1'b0, lat, bcnt, b0);
    chk("basic_product", product, 32'h0000000F);
`ifdef SHIFT_ADD_EARLY_TERM_EN
    chk("basic_latency_bound", (lat <= 17), 1'b1);
`else
    chk("basic_latency", lat, 17);
    chk("basic_busy_cycles", bcnt, 17);
`endif
    tick();
    chk("done_pulse_width", done, 1'b0);
    chk("product_held", product, 32'h0000000F);

    // Carry path through every step.
    run_op(16'hFFFF, 16'hFFFF, 1'b0, lat, bcnt, b0);
    chk("carry_product", product, 32'hFFFE0001);
`ifndef SHIFT_ADD_EARLY_TERM_EN
    chk("carry_latency", lat, 17);
`endif
    tick();

    // Reset during RUN cycle 8: outputs clear at once, no done pulse.
    mcand = 16'h00AB;
    mplr  = 16'h00CD;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_product", product, 32'h0);
    tick();
    tick();
    chk("abort_no_done", done, 1'b0);
    chk("abort_idle_busy", busy, 1'b0);

    rst = 1'b1;
    run_op(16'd2, 16'd9, 1'b0, lat, bcnt, b0);
    chk("after_abort_product", product, 32'd18);
`ifndef SHIFT_ADD_EARLY_TERM_EN
    chk("after_abort_latency", lat, 17);
`endif
    tick();

    // Zero multiplier; a start while busy must be ignored.
    run_op(16'h1234, 16'h0000, 1'b1, lat, bcnt, b0);
    chk("zero_product", product, 32'h0);
`ifndef SHIFT_ADD_EARLY_TERM_EN
    chk("zero_latency", lat, 17);
`endif
    tick();
    chk("ignored_start_idle", busy, 1'b0);

    // Back-to-back: second start is presented during the DONE cycle.
    run_op(16'h0101, 16'h0011, 1'b0, lat, bcnt, b0);
    chk("b2b_first_product", product, 32'h00001111);
    run_op(16'h0FFF, 16'h0003, 1'b0, lat, bcnt, b0);
    chk("b2b_no_idle", b0, 1'b1);
    chk("b2b_second_product", product, 32'h00002FFD);
`ifndef SHIFT_ADD_EARLY_TERM_EN
    chk("b2b_second_latency", lat, 17);
`endif
    tick();

    // Single set multiplier bit: early termination shortens latency.
    run_op(16'h1234, 16'h0001, 1'b0, lat, bcnt, b0);
    chk("single_bit_product", product, 32'h00001234);
`ifdef SHIFT_ADD_EARLY_TERM_EN
    chk("early_term_latency", (lat <= 3), 1'b1);
`else
    chk("single_bit_latency", lat, 17);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
